// File: rtl/hex_scan_display_pkg.sv
// Shared types and the active-low hex segment table for the multiplexed hex display.
package hex_scan_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Index is the nibble value; bit 0 is segment a, a low bit lights the segment.
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_7seg_decoder.sv
// Stateless nibble to active-low seven-segment decode.
module hex_7seg_decoder
    import hex_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver with frame-aligned value commit and
// optional leading-zero blanking.
module hex_scan_display
    import hex_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_DEFAULT = 1'b0
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    LOAD,
    input  logic                    BLANK_EN,
    output logic [6:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIG_EN,
    output logic                    COMMIT
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("hex_scan_display: NUM_DIGITS must be in 1..8");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("hex_scan_display: SCAN_DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] disp_value;
    logic [VAL_W-1:0] shadow_value;
    logic             disp_blank;
    logic             shadow_blank;
    logic             pending;
    logic             slot_end;
    logic             frame_end;
    logic [3:0]       cur_nibble;
    logic             cur_lead;
    logic             seen_nz;
    logic             blank_cur;
    logic [6:0]       dec_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Walk from the most significant digit down: cur_lead says whether any
    // nibble at or above the scanned digit is nonzero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the loop leaves it unassigned and infers a latch.
        cur_nibble = 4'h0;
        cur_lead   = 1'b0;
        seen_nz    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen_nz = seen_nz | (disp_value[4*k +: 4] != 4'h0);
            if (idx == IDX_W'(k)) begin
                cur_nibble = disp_value[4*k +: 4];
                cur_lead   = seen_nz;
            end
        end
    end

    assign blank_cur = disp_blank && (idx != '0) && !cur_lead;

    hex_7seg_decoder u_decoder (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            cnt          <= '0;
            idx          <= '0;
            disp_value   <= '0;
            shadow_value <= '0;
            disp_blank   <= BLANK_DEFAULT;
            shadow_blank <= BLANK_DEFAULT;
            pending      <= 1'b0;
            SEG          <= SEG_BLANK;
            DIG_EN       <= '1;
            COMMIT       <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // The display register only moves on a frame boundary, so a frame never tears.
            COMMIT <= 1'b0;
            if (frame_end && LOAD) begin
                disp_value <= VALUE;
                disp_blank <= BLANK_EN;
                pending    <= 1'b0;
                COMMIT     <= 1'b1;
            end else if (frame_end && pending) begin
                disp_value <= shadow_value;
                disp_blank <= shadow_blank;
                pending    <= 1'b0;
                COMMIT     <= 1'b1;
            end else if (LOAD) begin
                shadow_value <= VALUE;
                shadow_blank <= BLANK_EN;
                pending      <= 1'b1;
            end

            // First cycle of each slot keeps every digit dark to avoid ghosting.
            if (cnt == '0) begin
                DIG_EN <= '1;
                SEG    <= SEG_BLANK;
            end else begin
                DIG_EN <= ~(NUM_DIGITS'(1) << idx);
                SEG    <= blank_cur ? SEG_BLANK : dec_seg;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: a 4-digit/divide-by-4 instance driven
// from a vector table plus corner sequences, and a 1-digit/divide-by-2 instance.
module tb_hex_scan_display;

    typedef logic [3:0][6:0] digits_t;

    typedef struct {
        logic [15:0] value;
        logic        blank;
        digits_t     exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        blank_en;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        commit;

    logic        rst1_n;
    logic [3:0]  value1;
    logic        load1;
    logic        blank1;
    logic [6:0]  seg1;
    logic [0:0]  dig1;
    logic        commit1;

    int errors = 0;
    int checks = 0;

    vec_t vecs [8];

    hex_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_DEFAULT(1'b0)) u_dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .VALUE    (value),
        .LOAD     (load),
        .BLANK_EN (blank_en),
        .SEG      (seg),
        .DIG_EN   (dig_en),
        .COMMIT   (commit)
    );

    hex_scan_display #(.NUM_DIGITS(1), .SCAN_DIV(2), .BLANK_DEFAULT(1'b0)) u_dut1 (
        .CLOCK_50 (clk),
        .RESET_N  (rst1_n),
        .VALUE    (value1),
        .LOAD     (load1),
        .BLANK_EN (blank1),
        .SEG      (seg1),
        .DIG_EN   (dig1),
        .COMMIT   (commit1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic digits_t dg(input logic [6:0] d0, input logic [6:0] d1,
                                   input logic [6:0] d2, input logic [6:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // DIG_EN seen after the s-th edge of a frame (s = 1..16), 4 digits x 4 cycles.
    function automatic logic [3:0] exp_dig(input int s);
        int c;
        int i;
        c = (s - 1) % 4;
        i = ((s - 1) / 4) % 4;
        return (c == 0) ? 4'hF : ~(4'b0001 << i);
    endfunction

    // One full frame starting right after a boundary edge; optional LOADs at steps la/lb.
    task automatic frame_check(input string name, input digits_t exp,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb,
                               input logic bl, input logic exp_commit);
        for (int s = 1; s <= 16; s++) begin
            load     = (s == la) || (s == lb);
            value    = (s == lb) ? vb : va;
            blank_en = bl;
            step();
            load = 1'b0;
            check($sformatf("%s dig_en s%0d", name, s), {28'h0, dig_en}, {28'h0, exp_dig(s)});
            if ((s - 1) % 4 != 0)
                check($sformatf("%s seg d%0d s%0d", name, (s - 1) / 4, s),
                      {25'h0, seg}, {25'h0, exp[(s - 1) / 4]});
            check($sformatf("%s commit s%0d", name, s), {31'h0, commit},
                  {31'h0, (s == 16) && exp_commit});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        digits_t prev;
        logic [6:0] seg1_exp [1:8];

        vecs[0] = '{16'h12AF, 1'b0, dg(7'h0E, 7'h08, 7'h24, 7'h79)};
        vecs[1] = '{16'h0030, 1'b1, dg(7'h40, 7'h30, 7'h7F, 7'h7F)};
        vecs[2] = '{16'h0000, 1'b1, dg(7'h40, 7'h7F, 7'h7F, 7'h7F)};
        vecs[3] = '{16'h0000, 1'b0, dg(7'h40, 7'h40, 7'h40, 7'h40)};
        vecs[4] = '{16'h8C0D, 1'b1, dg(7'h21, 7'h40, 7'h46, 7'h00)};
        vecs[5] = '{16'h0500, 1'b1, dg(7'h40, 7'h40, 7'h12, 7'h7F)};
        vecs[6] = '{16'h3B67, 1'b0, dg(7'h78, 7'h02, 7'h03, 7'h30)};
        vecs[7] = '{16'h0E94, 1'b1, dg(7'h19, 7'h10, 7'h06, 7'h7F)};

        rst_n = 1'b0; load = 1'b0; value = '0; blank_en = 1'b0;
        rst1_n = 1'b0; load1 = 1'b0; value1 = '0; blank1 = 1'b0;

        // Reset held three cycles, then release and watch the first frame.
        repeat (3) step();
        check("reset seg", {25'h0, seg}, 32'h7F);
        check("reset dig_en", {28'h0, dig_en}, 32'hF);
        check("reset commit", {31'h0, commit}, 32'h0);
        rst_n = 1'b1;
        check("release dig_en s0", {28'h0, dig_en}, 32'hF);
        frame_check("first frame", dg(7'h40, 7'h40, 7'h40, 7'h40), 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

        // Each vector loads mid-frame; the frame keeps the old digits, the next shows the new.
        prev = dg(7'h40, 7'h40, 7'h40, 7'h40);
        for (int i = 0; i < 8; i++) begin
            frame_check($sformatf("vec%0d load", i), prev, 5, vecs[i].value, 0, 16'h0,
                        vecs[i].blank, 1'b1);
            prev = vecs[i].exp;
        end
        frame_check("vec7 shown", prev, 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

        // Two loads in one frame: last wins, a single commit.
        frame_check("two loads", prev, 3, 16'h1111, 9, 16'h2222, 1'b0, 1'b1);
        frame_check("two loads shown", dg(7'h24, 7'h24, 7'h24, 7'h24), 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

        // Load on the boundary edge goes straight to the display.
        frame_check("boundary load", dg(7'h24, 7'h24, 7'h24, 7'h24), 16, 16'h4321, 0, 16'h0, 1'b0, 1'b1);
        frame_check("boundary shown", dg(7'h79, 7'h24, 7'h30, 7'h19), 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

        // Reset in the middle of digit 2 with a coincident LOAD that must be dropped.
        repeat (10) step();
        rst_n = 1'b0; load = 1'b1; value = 16'hFFFF; blank_en = 1'b1;
        step();
        load = 1'b0;
        check("midreset seg", {25'h0, seg}, 32'h7F);
        check("midreset dig_en", {28'h0, dig_en}, 32'hF);
        check("midreset commit", {31'h0, commit}, 32'h0);
        rst_n = 1'b1;
        frame_check("after midreset", dg(7'h40, 7'h40, 7'h40, 7'h40), 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);
        frame_check("after midreset 2", dg(7'h40, 7'h40, 7'h40, 7'h40), 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

        // Single digit, divide by two: every slot wrap is a frame boundary.
        check("d1 reset seg", {25'h0, seg1}, 32'h7F);
        check("d1 reset dig_en", {31'h0, dig1}, 32'h1);
        check("d1 reset commit", {31'h0, commit1}, 32'h0);
        seg1_exp[2] = 7'h40;
        seg1_exp[4] = 7'h40;
        seg1_exp[6] = 7'h78;
        seg1_exp[8] = 7'h08;
        rst1_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            load1  = (k == 3) || (k == 6);
            value1 = (k == 3) ? 4'h7 : 4'hA;
            step();
            load1 = 1'b0;
            check($sformatf("d1 dig_en k%0d", k), {31'h0, dig1}, (k % 2 == 1) ? 32'h1 : 32'h0);
            if (k % 2 == 0)
                check($sformatf("d1 seg k%0d", k), {25'h0, seg1}, {25'h0, seg1_exp[k]});
            check($sformatf("d1 commit k%0d", k), {31'h0, commit1},
                  ((k == 4) || (k == 6)) ? 32'h1 : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
